// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } muldiv_state_t;

  // Quotient written on a divide by zero
  localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;

  // Magnitude of x when interpreted as signed (sgn=1); x unchanged otherwise
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  // Two's-complement negation when neg=1
  function automatic logic [31:0] cneg32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath: remainder/quotient shift registers, ITER_BITS
// restoring steps per clock. quo_nxt/rem_nxt show the values after the step
// that the next edge would take, so the caller can use the final step's result
// at the same edge it is computed.
module div_iter
  import mips_pkg::*;
#(
  parameter int ITER_BITS = 1
) (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_nxt,
  output logic [31:0] rem_nxt
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;

  // ITER_BITS restoring steps on the current shift-register contents
  always_comb begin
    // NOTE: blocking '=' inside always_comb lets each unrolled step see the
    // previous step's value; every variable gets a value before any branch,
    // so no latch is inferred.
    logic [31:0] r;
    logic [31:0] q;
    logic [31:0] rs;
    logic        ge;
    r = rem_q;
    q = quo_q;
    for (int i = 0; i < ITER_BITS; i++) begin
      rs = {r[30:0], q[31]};
      ge = ({r[31], rs} >= {1'b0, dvs_q});
      r  = ge ? (rs - dvs_q) : rs;
      q  = {q[30:0], ge};
    end
    quo_nxt = q;
    rem_nxt = r;
  end

  // Load operands on accept, advance one group of steps per running cycle
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers carry no reset; they are always loaded
    // before use, and the control FSM alone decides when results are valid.
    if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS multiply/divide unit owning HI/LO. Iterative shift-add multiply and
// restoring divide, N = 32/ITER_BITS cycles each.
// Optional feature macro: MULDIV_FAST_MULT_EN -- single-cycle MULT/MULTU.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int ITER_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int          N        = 32 / ITER_BITS;
  localparam logic [4:0]  LAST_CNT = 5'(N - 1);

  muldiv_state_t state, state_nxt;
  muldiv_op_t    op_e;
  logic          legal;
  logic          accept;
  logic          is_signed;
  logic          last;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;

  logic [4:0]    cnt;
  logic [31:0]   mcand;
  logic [63:0]   macc;
  logic [63:0]   macc_nxt;
  logic          neg_q;
  logic          neg_r;
  logic          dz;

  logic [31:0]   quo_nxt;
  logic [31:0]   rem_nxt;
  logic [63:0]   mul_res;
  logic [31:0]   div_q;
  logic [31:0]   div_r;

  assign op_e      = muldiv_op_t'(op);
  assign is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign a_mag     = mag32(op1, is_signed);
  assign b_mag     = mag32(op2, is_signed);
  assign accept    = start && (state == IDLE) && legal;
  assign last      = (cnt == LAST_CNT);

  // Decode legal op encodings; anything else is a no-op
  always_comb begin
    case (op_e)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: legal = 1'b1;
      default:                                              legal = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_e)
`ifdef MULDIV_FAST_MULT_EN
            MD_MULT, MD_MULTU: state_nxt = IDLE;
`else
            MD_MULT, MD_MULTU: state_nxt = RUN_MUL;
`endif
            MD_DIV, MD_DIVU:   state_nxt = RUN_DIV;
            default:           state_nxt = IDLE;
          endcase
        end
      end
      RUN_MUL, RUN_DIV: if (last) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Operand latch, sign capture and iteration counter
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt   <= '0;
      mcand <= a_mag;
      macc  <= {32'h0, b_mag};
      neg_q <= is_signed && (op1[31] ^ op2[31]);
      neg_r <= is_signed && op1[31];
      dz    <= (op2 == 32'h0);
    end else if (busy) begin
      cnt <= cnt + 5'd1;
      if (state == RUN_MUL) macc <= macc_nxt;
    end
  end

  // Shift-add multiply: ITER_BITS multiplier bits consumed per cycle
  always_comb begin
    logic [63:0] m;
    logic [32:0] sum;
    m = macc;
    for (int i = 0; i < ITER_BITS; i++) begin
      sum = {1'b0, m[63:32]} + (m[0] ? {1'b0, mcand} : 33'h0);
      m   = {sum, m[31:1]};
    end
    macc_nxt = m;
  end

  div_iter #(.ITER_BITS(ITER_BITS)) u_div (
    .clk      (clk),
    .load     (accept),
    .step     (state == RUN_DIV),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Sign fix-up of the final step; divide by zero overrides the quotient.
  // With a zero divisor the remainder is |op1|, which the sign fix restores to op1.
  assign mul_res = neg_q ? (~macc_nxt + 64'd1) : macc_nxt;
  assign div_q   = dz ? DIVZERO_Q : cneg32(quo_nxt, neg_q);
  assign div_r   = cneg32(rem_nxt, neg_r);

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod;
  assign fast_prod = is_signed
                   ? ({{32{op1[31]}}, op1} * {{32{op2[31]}}, op2})
                   : ({32'h0, op1} * {32'h0, op2});
`endif

  // HI/LO architectural registers and the done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (op_e)
          MD_MTHI: hi <= op1;
          MD_MTLO: lo <= op1;
`ifdef MULDIV_FAST_MULT_EN
          MD_MULT, MD_MULTU: begin
            {hi, lo} <= fast_prod;
            done     <= 1'b1;
          end
`endif
          default: ;
        endcase
      end else if (busy && last) begin
        done <= 1'b1;
        if (state == RUN_MUL) begin
          {hi, lo} <= mul_res;
        end else begin
          hi <= div_r;
          lo <= div_q;
        end
      end
    end
  end

endmodule
